// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder step (two half-adders plus OR) per clock.
// Operands are captured on start and consumed LSB-first. The sum fills MSB-in, and done pulses at the end.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  // state | meaning
  // IDLE  | waiting for start; result registers hold the last sum
  // RUN   | processing one operand bit per cycle
  // DONE  | result final; done pulses for this single cycle
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa, sb;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             ha1_s, ha1_c, ha2_s, ha2_c, cy;

  assign ha1_s = sa[0] ^ sb[0];
  assign ha1_c = sa[0] & sb[0];
  assign ha2_s = ha1_s ^ c;
  assign ha2_c = ha1_s & c;
  assign cy    = ha1_c | ha2_c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa        <= '0;
      sb        <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa        <= a;
            sb        <= b;
            c         <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
          end
        end
        RUN: begin
          sum <= {ha2_s, sum[WIDTH-1:1]};
          c   <= cy;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          if (cnt == LAST) carry_out <= cy;
          else             cnt       <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table vectors, multi-cycle corner sequences,
// and a randomized sweep at WIDTH=8 and WIDTH=16 compared against plain a+b arithmetic.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  logic start8, start16;
  logic [7:0]  a8, b8, sum8;
  logic [15:0] a16, b16, sum16;
  logic busy8, done8, co8, busy16, done16, co16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8));

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       co;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One 8-bit operation. k counts the edges after the accepting edge E0.
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input bit inject,
                         output logic [7:0] s, output logic co,
                         output int busy_n, output int done_n, output int done_k);
    s = '0; co = 1'b0; busy_n = 0; done_n = 0; done_k = -1;
    @(negedge clk); start8 = 1'b1; a8 = av; b8 = bv;
    @(negedge clk); start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int k = 0; k < 12; k++) begin
      if (busy8) busy_n++;
      if (done8) begin done_n++; done_k = k; s = sum8; co = co8; end
      if (inject && k == 3) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
      else start8 = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t vecs[7];
    logic [7:0] s;
    logic co;
    int bn, dn, dk;
    logic [16:0] exp16;
    logic [8:0]  exp8;
    logic [7:0]  ra, rb;
    logic [15:0] ra16, rb16;
    int last_done, pulses, waited;
    logic [7:0] held;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 8'h0F, 8'h4B, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 8'h46, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 8'h00, 1'b1};

    rst = 1'b1; start8 = 1'b1; start16 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; a16 = '1; b16 = '1;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy8), 64'd0);
    check("reset_done", 64'(done8), 64'd0);
    check("reset_sum", 64'(sum8), 64'd0);
    check("reset_co", 64'(co8), 64'd0);
    check("reset_busy16", 64'(busy16), 64'd0);
    rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op8(vecs[i].a, vecs[i].b, 1'b0, s, co, bn, dn, dk);
      check($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].s));
      check($sformatf("vec%0d_co", i), 64'(co), 64'(vecs[i].co));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bn), 64'd8);
      check($sformatf("vec%0d_done_count", i), 64'(dn), 64'd1);
      check($sformatf("vec%0d_done_latency", i), 64'(dk), 64'd8);
      check($sformatf("vec%0d_sum_held", i), 64'(sum8), 64'(vecs[i].s));
    end

    // start during RUN must be ignored
    run_op8(8'hA5, 8'h5A, 1'b1, s, co, bn, dn, dk);
    check("inject_sum", 64'(s), 64'hFF);
    check("inject_co", 64'(co), 64'd0);
    check("inject_done_count", 64'(dn), 64'd1);
    check("inject_sum_held", 64'(sum8), 64'hFF);
    check("inject_busy_after", 64'(busy8), 64'd0);

    // reset in the 4th RUN cycle aborts the operation
    @(negedge clk); start8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_sum", 64'(sum8), 64'd0);
    check("abort_co", 64'(co8), 64'd0);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8 || busy8) dn++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dn), 64'd0);
    run_op8(8'h3C, 8'h0F, 1'b0, s, co, bn, dn, dk);
    check("after_abort_sum", 64'(s), 64'h4B);
    check("after_abort_co", 64'(co), 64'd0);

    // start held high, alternating operand pairs
    @(negedge clk); start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    last_done = -1; pulses = 0; held = '0;
    for (int t = 0; t < 60 && pulses < 4; t++) begin
      @(negedge clk);
      if (pulses > 0 && t == last_done + 1)
        check($sformatf("held_sum_stable%0d", pulses), 64'(sum8), 64'(held));
      if (done8) begin
        if (pulses[0] == 1'b0) begin
          check($sformatf("held_sum%0d", pulses), 64'(sum8), 64'h46);
          check($sformatf("held_co%0d", pulses), 64'(co8), 64'd0);
          a8 = 8'h80; b8 = 8'h80;
        end else begin
          check($sformatf("held_sum%0d", pulses), 64'(sum8), 64'h00);
          check($sformatf("held_co%0d", pulses), 64'(co8), 64'd1);
          a8 = 8'h12; b8 = 8'h34;
        end
        if (last_done >= 0)
          check($sformatf("held_interval%0d", pulses), 64'(t - last_done), 64'd10);
        held = sum8;
        last_done = t;
        pulses++;
      end
    end
    check("held_pulse_count", 64'(pulses), 64'd4);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    // randomized sweep, WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      exp8 = {1'b0, ra} + {1'b0, rb};
      @(negedge clk); start8 = 1'b1; a8 = ra; b8 = rb;
      @(negedge clk); start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      waited = 0;
      while (!done8 && waited < 20) begin @(negedge clk); waited++; end
      if (!done8) check($sformatf("rand8_%0d_timeout", i), 64'd0, 64'd1);
      else        check($sformatf("rand8_%0d_result", i), 64'({co8, sum8}), 64'(exp8));
    end

    // randomized sweep, WIDTH=16
    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom);
      exp16 = {1'b0, ra16} + {1'b0, rb16};
      @(negedge clk); start16 = 1'b1; a16 = ra16; b16 = rb16;
      @(negedge clk); start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      waited = 0;
      while (!done16 && waited < 30) begin @(negedge clk); waited++; end
      if (!done16) check($sformatf("rand16_%0d_timeout", i), 64'd0, 64'd1);
      else         check($sformatf("rand16_%0d_result", i), 64'({co16, sum16}), 64'(exp16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
